// File: rtl/simon_pkg.sv
`timescale 1ns/1ps
// simon_pkg: SIMON 64/96 constants, FSM state type and 32-bit word helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package simon_pkg;

    localparam int WORD_W           = 32;
    localparam int NUM_ROUNDS_64_96 = 42;
    localparam int KEY_WORDS_64_96  = 3;

    localparam logic [WORD_W-1:0] SIMON_C = 32'hFFFFFFFC;

    // z2 sequence, first element in the MSB: z_j = SIMON_Z2[61 - j]
    localparam logic [61:0] SIMON_Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2,
        DONE    = 2'd3
    } simonState_t;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    // SIMON round function f(v) = (S^1 v & S^8 v) ^ S^2 v
    function automatic logic [WORD_W-1:0] roundF(input logic [WORD_W-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    // z_j for j in 0..61
    function automatic logic zBit(input logic [5:0] idx);
        logic [5:0] pos;
        pos = 6'd61 - idx;
        return SIMON_Z2[pos];
    endfunction

endpackage

// File: rtl/simon_key_step.sv
`timescale 1ns/1ps
// simon_key_step: one SIMON m=3 key-schedule step, C ^ z ^ k_far ^ S^-3(k_near) ^ S^-4(k_near).
// Latency: combinational.
// Backpressure: none; forward step uses (k[j], k[j+2]), inverse step uses (k[r], k[r-1]).
module simon_key_step
    import simon_pkg::*;
(
    input  logic [WORD_W-1:0] k_far,
    input  logic [WORD_W-1:0] k_near,
    input  logic              z_bit,
    output logic [WORD_W-1:0] k_out
);

    logic [WORD_W-1:0] nearMix;

    assign nearMix = rotr(k_near, 3) ^ rotr(k_near, 4);
    assign k_out   = SIMON_C ^ {{(WORD_W-1){1'b0}}, z_bit} ^ k_far ^ nearMix;

endmodule

// File: rtl/simon_decrypt_64_96.sv
`timescale 1ns/1ps
// simon_decrypt_64_96: iterative SIMON 64/96 decryptor (key expansion, then one round per clock).
// Latency: 81 cycles accept->out_valid; 42 on a key-cache hit when SIMON_KEY_CACHE_EN is defined.
// Backpressure: one job in flight; in_ready only in IDLE, result held in DONE until out_ready.
module simon_decrypt_64_96
    import simon_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_64_96,
    parameter int KEY_WORDS  = KEY_WORDS_64_96
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [95:0] key_in,
    input  logic [63:0] ct_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] pt_out,
    output logic        out_valid,
    input  logic        out_ready
);

    generate
        if (NUM_ROUNDS != NUM_ROUNDS_64_96 || KEY_WORDS != KEY_WORDS_64_96) begin : gBadParams
            $error("simon_decrypt_64_96 supports only NUM_ROUNDS=42 and KEY_WORDS=3");
        end
    endgenerate

    // last forward-expansion index (k[41] is produced at j=38) and first decrypt round
    localparam logic [5:0] EXPAND_LAST = 6'(NUM_ROUNDS - KEY_WORDS - 1);
    localparam logic [5:0] LAST_ROUND  = 6'(NUM_ROUNDS - 1);

    simonState_t state, nextState;

    logic [5:0]        roundCnt;
    logic [WORD_W-1:0] keyWin0, keyWin1, keyWin2;   // keyWin2 holds the newest/current key
    logic [WORD_W-1:0] dataX, dataY;
    logic [63:0]       ptOut;

    logic              acceptJob;
    logic              expandLast;
    logic [5:0]        zIdx;
    logic              stepZ;
    logic [WORD_W-1:0] stepFar, stepNear, stepKey;
    logic [WORD_W-1:0] newY;

    logic              cacheHit;
    logic [WORD_W-1:0] cacheK39, cacheK40, cacheK41;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign pt_out     = ptOut;
    assign acceptJob  = (state == IDLE) && in_valid;
    assign expandLast = (state == EXPAND) && (roundCnt == EXPAND_LAST);

    // one key-step instance serves both directions; rounds r<3 need no new key, so z index is parked at 0
    assign stepFar  = (state == EXPAND) ? keyWin0 : keyWin2;
    assign stepNear = (state == EXPAND) ? keyWin2 : keyWin1;
    assign zIdx     = (state == EXPAND)    ? roundCnt :
                      (roundCnt >= 6'd3)   ? roundCnt - 6'd3 : 6'd0;
    assign stepZ    = zBit(zIdx);

    simon_key_step uKeyStep (
        .k_far  (stepFar),
        .k_near (stepNear),
        .z_bit  (stepZ),
        .k_out  (stepKey)
    );

    assign newY = dataX ^ roundF(dataY) ^ keyWin2;

`ifdef SIMON_KEY_CACHE_EN
    logic        cacheVld;
    logic [95:0] cacheKey;
    logic [95:0] jobKey;

    assign cacheHit = cacheVld && (key_in == cacheKey);

    // remember the job's key and capture {k39,k40,k41} as expansion completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cacheVld <= 1'b0;
            cacheKey <= '0;
            jobKey   <= '0;
            cacheK39 <= '0;
            cacheK40 <= '0;
            cacheK41 <= '0;
        end else begin
            if (acceptJob) begin
                jobKey <= key_in;
            end
            if (expandLast) begin
                cacheVld <= 1'b1;
                cacheKey <= jobKey;
                cacheK39 <= keyWin1;
                cacheK40 <= keyWin2;
                cacheK41 <= stepKey;
            end
        end
    end
`else
    assign cacheHit = 1'b0;
    assign cacheK39 = '0;
    assign cacheK40 = '0;
    assign cacheK41 = '0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // next-state: accept -> expand (or straight to decrypt on a cache hit) -> decrypt -> done
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    nextState = cacheHit ? DECRYPT : EXPAND;
                end
            end
            EXPAND: begin
                if (roundCnt == EXPAND_LAST) begin
                    nextState = DECRYPT;
                end
            end
            DECRYPT: begin
                if (roundCnt == 6'd0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // datapath: key window, round counter, data halves and held plaintext
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roundCnt <= '0;
            keyWin0  <= '0;
            keyWin1  <= '0;
            keyWin2  <= '0;
            dataX    <= '0;
            dataY    <= '0;
            ptOut    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dataX <= ct_in[63:32];
                        dataY <= ct_in[31:0];
                        if (cacheHit) begin
                            keyWin0  <= cacheK39;
                            keyWin1  <= cacheK40;
                            keyWin2  <= cacheK41;
                            roundCnt <= LAST_ROUND;
                        end else begin
                            keyWin0  <= key_in[31:0];
                            keyWin1  <= key_in[63:32];
                            keyWin2  <= key_in[95:64];
                            roundCnt <= 6'd0;
                        end
                    end
                end
                EXPAND: begin
                    keyWin0 <= keyWin1;
                    keyWin1 <= keyWin2;
                    keyWin2 <= stepKey;
                    if (roundCnt == EXPAND_LAST) begin
                        roundCnt <= LAST_ROUND;
                    end else begin
                        roundCnt <= roundCnt + 6'd1;
                    end
                end
                DECRYPT: begin
                    dataX   <= dataY;
                    dataY   <= newY;
                    keyWin2 <= keyWin1;
                    keyWin1 <= keyWin0;
                    keyWin0 <= (roundCnt >= 6'd3) ? stepKey : '0;
                    if (roundCnt == 6'd0) begin
                        ptOut <= {dataY, newY};
                    end else begin
                        roundCnt <= roundCnt - 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_decrypt_64_96.sv
`timescale 1ns/1ps
// tb_simon_decrypt_64_96: scoreboard bench for the SIMON 64/96 decryptor.
// Latency: checks 81-cycle (or 42-cycle cached) accept->out_valid per job.
// Backpressure: exercises DONE hold, ignored in_valid, async reset mid-job, back-to-back jobs.
module tb_simon_decrypt_64_96;
    import simon_pkg::*;

    localparam logic [95:0] KEY1 = 96'h131211100b0a090803020100;
    localparam logic [95:0] KEY2 = 96'h1b1a1918131211100b0a0908;
    localparam logic [63:0] CT1  = 64'h5ca2e27f111a8fc8;
    localparam logic [63:0] PT1  = 64'h6f7220676e696c63;
    localparam logic [31:0] K3   = 32'hffae9dce;
    localparam logic [31:0] K4   = 32'hc4facc91;
    localparam int          LAT_FULL = 81;
`ifdef SIMON_KEY_CACHE_EN
    localparam int          LAT_REPEAT = 42;
`else
    localparam int          LAT_REPEAT = 81;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] key_in;
    logic [63:0] ct_in;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pt_out;
    logic        out_valid;
    logic        out_ready;

    simon_decrypt_64_96 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .ct_in     (ct_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt_out    (pt_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pt;
        int          accCyc;
        int          lat;
        bit          chkPt;
    } exp_t;

    exp_t        sbQ[$];
    int          vecCnt = 0;
    int          errCnt = 0;
    int          cyc = 0;
    int          outCnt = 0;
    int          probeHits = 0;
    bit          probeEn = 1'b0;
    bit          seen = 1'b0;
    logic [63:0] curPt = '0;
    int          curLat = 0;
    bit          curChk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vecCnt++;
        if (act !== req) begin
            errCnt++;
            $display("FAIL %s: actual %h, required %h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // accept monitor: the coming edge is E0, so the expected result is queued now
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sbQ.push_back('{pt: curPt, accCyc: cyc + 1, lat: curLat, chkPt: curChk});
        end
    end

    // output monitor: compare once per result on the first cycle out_valid is seen
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid && !seen) begin
            seen = 1'b1;
            outCnt++;
            if (sbQ.size() == 0) begin
                check("unexpected output", 64'd1, 64'd0);
            end else begin
                e = sbQ.pop_front();
                if (e.chkPt) check("plaintext", pt_out, e.pt);
                check("latency", 64'(cyc - e.accCyc), 64'(e.lat));
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    // key window probes: forward k3/k4 during expansion, regenerated k4/k3 during decryption
    always @(negedge clk) begin
        if (probeEn && rst_n) begin
            if (dut.state == EXPAND && dut.roundCnt == 6'd1) begin
                check("expand k3", 64'(dut.keyWin2), 64'(K3));
                probeHits++;
            end
            if (dut.state == EXPAND && dut.roundCnt == 6'd2) begin
                check("expand k4", 64'(dut.keyWin2), 64'(K4));
                probeHits++;
            end
            if (dut.state == DECRYPT && dut.roundCnt == 6'd4) begin
                check("inverse k4", 64'(dut.keyWin2), 64'(K4));
                probeHits++;
            end
            if (dut.state == DECRYPT && dut.roundCnt == 6'd3) begin
                check("inverse k3", 64'(dut.keyWin2), 64'(K3));
                probeHits++;
            end
        end
    end

    task automatic issue(input logic [95:0] key, input logic [63:0] ct, input logic [63:0] pt,
                         input int lat, input bit chk);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready before issue", 64'(in_ready), 64'd1);
        key_in   = key;
        ct_in    = ct;
        curPt    = pt;
        curLat   = lat;
        curChk   = chk;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOuts(input int target, input string name);
        int n = 0;
        while (outCnt < target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(outCnt), 64'(target));
    endtask

    initial begin
        int base;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        key_in    = '0;
        ct_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset pt_out", pt_out, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // job 1 with window probes, then a held DONE phase
        probeEn   = 1'b1;
        out_ready = 1'b0;
        issue(KEY1, CT1, PT1, LAT_FULL, 1'b1);
        waitOuts(1, "job1 output");
        probeEn = 1'b0;
        check("window probes seen", 64'(probeHits), 64'd4);
        for (int i = 0; i < 10; i++) begin
            ct_in    = 64'h0123456789abcdef;
            in_valid = (i >= 3 && i < 6);
            @(posedge clk); #1;
            check("hold out_valid", 64'(out_valid), 64'd1);
            check("hold pt_out", pt_out, PT1);
            check("hold in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("handshake out_valid", 64'(out_valid), 64'd0);
        check("handshake pt_out held", pt_out, PT1);
        check("handshake in_ready", 64'(in_ready), 64'd1);

        // async reset in the middle of decryption, then a clean re-run
        issue(KEY1, CT1, PT1, LAT_REPEAT, 1'b1);
        n = 0;
        while (!(dut.state == DECRYPT && dut.roundCnt == 6'd20) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached round 20", 64'(n < 200), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset in_ready", 64'(in_ready), 64'd1);
        sbQ.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = outCnt;
        issue(KEY1, CT1, PT1, LAT_FULL, 1'b1);
        waitOuts(base + 1, "post-reset output");

        // back-to-back: in_valid and out_ready held high for three jobs
        base     = outCnt;
        key_in   = KEY1;
        ct_in    = CT1;
        curPt    = PT1;
        curLat   = LAT_REPEAT;
        curChk   = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (outCnt < base + 3 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("back-to-back outputs", 64'(outCnt), 64'(base + 3));

        // key change: full expansion, repeat of the new key, then back to KEY1
        base = outCnt;
        issue(KEY2, CT1, 64'd0, LAT_FULL, 1'b0);
        waitOuts(base + 1, "new key output");
        issue(KEY2, CT1, 64'd0, LAT_REPEAT, 1'b0);
        waitOuts(base + 2, "repeat new key output");
        issue(KEY1, CT1, PT1, LAT_FULL, 1'b1);
        waitOuts(base + 3, "key1 after change output");

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard drained", 64'(sbQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
